sysid_checker: RTL and testbench
================================

// Module: sysid_checker
// PURPOSE
//  Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 = build timestamp).
//  Compares both words against expected values. Reports pass/fail to the boot/status logic.
//  Software can rely on the result before the Nios core trusts the HW/SW pairing.
//  Sits between the system interconnect and the status/LED register block.
// PARAMETERS
//  EXPECTED_ID     32'd0           expected word at address 0
//  EXPECTED_TS     32'd1369725685  expected word at address 1 (build timestamp)
//  READ_LATENCY    0               fixed slave read latency in cycles, legal 0..3
//  TIMEOUT_CYCLES  255             max cycles read may stall on waitrequest, 1..65535
//  AUTO_START      1               1 = launch one check automatically after reset release
// PORTS
//  clock          in   1   system clock
//  reset_n        in   1   asynchronous active-low reset
//  start          in   1   one-cycle pulse: launch a check (ignored while busy)
//  address        out  1   Avalon word address to sysid slave (0 = ID, 1 = timestamp)
//  read           out  1   Avalon read request
//  waitrequest    in   1   slave stall; tie 0 if slave has none
//  readdata       in   32  Avalon read data
//  busy           out  1   check in progress
//  done           out  1   one-cycle pulse when a check completes (pass, fail or timeout)
//  id_ok          out  1   captured ID == EXPECTED_ID (sticky until next start)
//  ts_ok          out  1   captured timestamp == EXPECTED_TS (sticky until next start)
//  timeout_err    out  1   a read stalled > TIMEOUT_CYCLES (sticky until next start)
//  id_value       out  32  last captured ID word
//  ts_value       out  32  last captured timestamp word
// BEHAVIOUR
//  Reset: all outputs 0. State = IDLE. Timeout and latency counters = 0. All outputs are registered.
//  FSM: IDLE -> RD_ID -> LAT_ID -> RD_TS -> LAT_TS -> DONE -> IDLE; ERR -> DONE on timeout.
//  IDLE: a launch goes to RD_ID and clears id_ok/ts_ok/timeout_err.
//    Launch = start=1, or the first cycle after reset release when AUTO_START=1.
//  RD_ID: read=1, address=0. Hold both stable while waitrequest=1.
//    Accept = read & ~waitrequest.
//    LATENCY=0: capture readdata into id_value in the accept cycle, go to RD_TS.
//    LATENCY>0: go to LAT_ID and capture on its READ_LATENCY-th cycle.
//      Example: LATENCY=1 captures in the cycle after accept.
//  RD_TS / LAT_TS: same rules with address=1; capture into ts_value.
//  Timeout counter: cleared at entry to each RD_* state; increments per cycle with waitrequest=1.
//    If it reaches TIMEOUT_CYCLES with waitrequest still 1, go to ERR.
//  ERR: read=0, timeout_err=1, id_ok/ts_ok stay 0, then DONE.
//  DONE: id_ok/ts_ok updated from the compare, done=1 for exactly one cycle, busy=0 next cycle.
//  busy = 1 in every state except IDLE.
//  Latency, zero wait, READ_LATENCY=0: start at cycle 0, read asserted cycles 1..2, done at cycle 4.
//  Read is deasserted in LAT_* states; at most one outstanding read.
//  start while busy: ignored, no queuing.
//  start in the same cycle as done: ignored; a new start is needed once IDLE.
//  Async reset mid-transfer: read drops immediately. Any late readdata is ignored; restart from IDLE.
//    If AUTO_START=1 the check relaunches.
//  Compare is exact 32-bit equality; no masking.
// STRUCTURE
//  Shared package sysid_pkg:
//    state enum encoding (IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, ERR, DONE)
//    ADDR_ID=1'b0, ADDR_TS=1'b1
//    SYSID_TS_DEFAULT constant
//  One sub-module: avm_read_beat, a single-read engine.
//    Handles the waitrequest hold, timeout counter and fixed-latency capture.
//    Interface: go, addr, rdata_out, capture pulse, timeout pulse.
//    Instanced once and sequenced by the top-level FSM.
// TESTING
//  1 Zero-wait, LAT=0: slave returns 0 / 1369725685 after reset.
//      -> auto check; done pulse at cycle 4; id_ok=1, ts_ok=1, timeout_err=0.
//  2 Mismatch: slave returns ID 0, timestamp 1369725686.
//      -> id_ok=1, ts_ok=0, ts_value=1369725686, one done pulse.
//  3 Stall: waitrequest=1 for 10 cycles on address 1, TIMEOUT_CYCLES=255.
//      -> address/read held stable all 10 cycles; pass; done 10 cycles later than test 1.
//  4 Timeout: waitrequest stuck 1, TIMEOUT_CYCLES=16.
//      -> read drops after 16 stall cycles; timeout_err=1, id_ok=0, ts_ok=0, done pulses once.
//  5 LAT=2: readdata valid only 2 cycles after accept, garbage in between.
//      -> garbage not captured; correct values captured; pass.
//  6 start pulsed while busy and again the same cycle as done -> both ignored.
//    reset_n pulsed low mid-RD_TS -> outputs 0 asynchronously; relaunch passes.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker.
//   state_t          : checker sequencing states
//   ADDR_ID/ADDR_TS  : word addresses of the sysid slave
//   SYSID_TS_DEFAULT : build timestamp expected by default
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        ERR,
        DONE
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_TS_DEFAULT = 32'd1369725685;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
//   address     : word address (0 = ID, 1 = timestamp)
//   read        : read request
//   waitrequest : slave stall
//   readdata    : 32-bit read data
interface sysid_checker_if;

    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (output address, read, input waitrequest, readdata);
    modport slave  (input address, read, output waitrequest, readdata);

endinterface

// File: rtl/avm_read_beat.sv
// Single Avalon-MM read engine: issues one read per go pulse, holds it through
// waitrequest, aborts after TIMEOUT_CYCLES stall cycles and captures readdata
// READ_LATENCY cycles after the read is accepted.
//   clock, reset_n : clock and asynchronous active-low reset
//   go, addr       : start a read at addr (takes priority over ending the current one)
//   read, address  : bus request, registered
//   waitrequest    : bus stall
//   readdata       : bus read data
//   accept         : read accepted by the slave this cycle
//   capture        : rdata_out holds the valid word this cycle
//   timeout        : read abandoned this cycle
//   rdata_out      : read data toward the sequencer
module avm_read_beat
    import sysid_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        go,
    input  logic        addr,
    output logic        read,
    output logic        address,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        accept,
    output logic        capture,
    output logic        timeout,
    output logic [31:0] rdata_out
);

    localparam logic [1:0]  LAT     = 2'(READ_LATENCY);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;
    logic [1:0]  lat_cnt;
    logic        lat_busy;

    assign accept    = read & ~waitrequest;
    // The stall that brings the count to TIMEOUT_CYCLES is the last one tolerated.
    assign timeout   = read & waitrequest & (wait_cnt == TO_LAST);
    assign capture   = (LAT == 2'd0) ? accept : (lat_busy & (lat_cnt == LAT));
    assign rdata_out = readdata;

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read     <= 1'b0;
            address  <= ADDR_ID;
            wait_cnt <= '0;
            lat_cnt  <= '0;
            lat_busy <= 1'b0;
        end else begin
            if (accept || timeout) read <= 1'b0;
            if (read && waitrequest) wait_cnt <= wait_cnt + 16'd1;

            // The first latency cycle after accept counts as 1.
            if (accept && (LAT != 2'd0)) begin
                lat_busy <= 1'b1;
                lat_cnt  <= 2'd1;
            end else if (lat_busy) begin
                if (lat_cnt == LAT) lat_busy <= 1'b0;
                else lat_cnt <= lat_cnt + 2'd1;
            end

            // A new read may be launched in the cycle the previous one completes.
            if (go) begin
                read     <= 1'b1;
                address  <= addr;
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// Reads the sysid slave (ID, then build timestamp), compares both words with
// the expected values and reports the outcome to the boot/status logic.
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : one-cycle launch pulse, ignored while busy
//   avm            : Avalon-MM master toward the sysid slave
//   busy           : check in progress (drops the cycle after done)
//   done           : one-cycle completion pulse
//   id_ok, ts_ok   : compare results, sticky until the next launch
//   timeout_err    : a read stalled too long, sticky until the next launch
//   id_value       : last captured ID word
//   ts_value       : last captured timestamp word
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = SYSID_TS_DEFAULT,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          AUTO_START     = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    sysid_checker_if.master avm,
    output logic            busy,
    output logic            done,
    output logic            id_ok,
    output logic            ts_ok,
    output logic            timeout_err,
    output logic [31:0]     id_value,
    output logic [31:0]     ts_value
);

    state_t      state;
    logic        auto_pend;
    logic        launch;
    logic        go;
    logic        go_addr;
    logic        accept;
    logic        capture;
    logic        timeout;
    logic [31:0] rdata;

    avm_read_beat #(
        .READ_LATENCY  (READ_LATENCY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_beat (
        .clock      (clock),
        .reset_n    (reset_n),
        .go         (go),
        .addr       (go_addr),
        .read       (avm.read),
        .address    (avm.address),
        .waitrequest(avm.waitrequest),
        .readdata   (avm.readdata),
        .accept     (accept),
        .capture    (capture),
        .timeout    (timeout),
        .rdata_out  (rdata)
    );

    // busy is still high during the done cycle, so a start there is ignored.
    assign launch = (start | auto_pend) & ~busy;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        go      = 1'b0;
        go_addr = ADDR_ID;
        case (state)
            IDLE:           go = launch;
            RD_ID, LAT_ID:  if (capture) begin
                                go      = 1'b1;
                                go_addr = ADDR_TS;
                            end
            default:        ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            auto_pend   <= (AUTO_START != 0);
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            auto_pend <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state       <= RD_ID;
                        busy        <= 1'b1;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout_err <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RD_ID: begin
                    if (timeout) state <= ERR;
                    else if (capture) begin
                        id_value <= rdata;
                        state    <= RD_TS;
                    end else if (accept) state <= LAT_ID;
                end
                LAT_ID: begin
                    if (capture) begin
                        id_value <= rdata;
                        state    <= RD_TS;
                    end
                end
                RD_TS: begin
                    if (timeout) state <= ERR;
                    else if (capture) begin
                        ts_value <= rdata;
                        state    <= DONE;
                    end else if (accept) state <= LAT_TS;
                end
                LAT_TS: begin
                    if (capture) begin
                        ts_value <= rdata;
                        state    <= DONE;
                    end
                end
                ERR: begin
                    timeout_err <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    // After a timeout the compare flags stay cleared.
                    if (!timeout_err) begin
                        id_ok <= (id_value == EXPECTED_ID);
                        ts_ok <= (ts_value == EXPECTED_TS);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: dut_a runs with zero read latency and a long timeout,
// dut_b with READ_LATENCY=2 and a 16-cycle timeout. Each has a small slave model;
// expected outcomes come from a cycle-count model of the check sequence.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1369725685;
    localparam int          TO_A   = 255;
    localparam int          TO_B   = 16;
    localparam int          LAT_B  = 2;

    typedef struct {
        int          done_cyc;
        logic        id_ok;
        logic        ts_ok;
        logic        to_err;
        logic [31:0] id_v;
        logic [31:0] ts_v;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  rst_n_v = 2'b00;
    logic [1:0]  start_v = 2'b00;
    logic [1:0]  busy_o, done_o, idok_o, tsok_o, toerr_o;
    logic [31:0] idv_o [2];
    logic [31:0] tsv_o [2];
    logic [1:0]  rd_o, addr_o, wr_o;

    // Slave configuration written by the stimulus.
    logic [31:0] id_s [2]     = '{32'd0, 32'd0};
    logic [31:0] ts_s [2]     = '{32'd0, 32'd0};
    int          stall_id [2] = '{0, 0};
    int          stall_ts [2] = '{0, 0};
    logic [31:0] last_id [2]  = '{32'd0, 32'd0};
    logic [31:0] last_ts [2]  = '{32'd0, 32'd0};

    sysid_checker_if a_if ();
    sysid_checker_if b_if ();

    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
        .READ_LATENCY(0), .TIMEOUT_CYCLES(TO_A), .AUTO_START(1)
    ) dut_a (
        .clock(clock), .reset_n(rst_n_v[0]), .start(start_v[0]), .avm(a_if),
        .busy(busy_o[0]), .done(done_o[0]), .id_ok(idok_o[0]), .ts_ok(tsok_o[0]),
        .timeout_err(toerr_o[0]), .id_value(idv_o[0]), .ts_value(tsv_o[0])
    );

    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
        .READ_LATENCY(LAT_B), .TIMEOUT_CYCLES(TO_B), .AUTO_START(1)
    ) dut_b (
        .clock(clock), .reset_n(rst_n_v[1]), .start(start_v[1]), .avm(b_if),
        .busy(busy_o[1]), .done(done_o[1]), .id_ok(idok_o[1]), .ts_ok(tsok_o[1]),
        .timeout_err(toerr_o[1]), .id_value(idv_o[1]), .ts_value(tsv_o[1])
    );

    assign rd_o   = {b_if.read, a_if.read};
    assign addr_o = {b_if.address, a_if.address};
    assign wr_o   = {b_if.waitrequest, a_if.waitrequest};

    // Slave A: zero latency, stalls each read for a configured number of cycles.
    logic [31:0] garbage = 32'hdead_beef;
    int          a_run   = 0;
    always @(posedge clock) begin
        garbage <= $urandom();
        if (a_if.read && !a_if.waitrequest) a_run <= 0;
        else if (a_if.read) a_run <= a_run + 1;
        else a_run <= 0;
    end
    assign a_if.waitrequest = a_if.read && (a_run < (a_if.address ? stall_ts[0] : stall_id[0]));
    assign a_if.readdata    = (a_if.read && !a_if.waitrequest) ? (a_if.address ? ts_s[0] : id_s[0])
                                                               : garbage;

    // Slave B: data valid exactly two cycles after accept, garbage otherwise;
    // a nonzero stall_id[1] means waitrequest is stuck high.
    logic [1:0]  b_vld = 2'b00;
    logic [31:0] b_d0  = 32'd0;
    logic [31:0] b_d1  = 32'd0;
    always @(posedge clock) begin
        b_vld <= {b_vld[0], b_if.read && !b_if.waitrequest};
        b_d0  <= b_if.address ? ts_s[1] : id_s[1];
        b_d1  <= b_d0;
    end
    assign b_if.waitrequest = (stall_id[1] != 0);
    assign b_if.readdata    = b_vld[1] ? b_d1 : garbage;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Outcome of one check: cycle 1 is the first cycle after the launch edge.
    function automatic exp_t predict(input logic [31:0] id, input logic [31:0] ts,
                                     input int sid, input int sts, input int lat, input int to,
                                     input logic [31:0] prev_id, input logic [31:0] prev_ts);
        exp_t e;
        e.id_v   = prev_id;
        e.ts_v   = prev_ts;
        e.id_ok  = 1'b0;
        e.ts_ok  = 1'b0;
        e.to_err = 1'b0;
        if (sid >= to) begin
            e.to_err   = 1'b1;
            e.done_cyc = to + 3;
        end else begin
            e.id_v = id;
            if (sts >= to) begin
                e.to_err   = 1'b1;
                e.done_cyc = sid + lat + to + 4;
            end else begin
                e.ts_v     = ts;
                e.id_ok    = (id == EXP_ID);
                e.ts_ok    = (ts == EXP_TS);
                e.done_cyc = 4 + sid + sts + 2 * lat;
            end
        end
        return e;
    endfunction

    // One complete check on dut d, launched by start or by reset release.
    // poke drives start while busy (cycle 2) and in the done cycle.
    task automatic run(input int d, input string tag, input logic [31:0] id, input logic [31:0] ts,
                       input int sid, input int sts, input bit use_start, input bit poke);
        exp_t e;
        int   lat        = (d == 0) ? 0 : LAT_B;
        int   to         = (d == 0) ? TO_A : TO_B;
        int   done_at    = -1;
        int   dones      = 0;
        int   rd_cyc     = 0;
        int   hold_bad   = 0;
        int   exp_rd;
        logic busy_done  = 1'b0;
        logic busy_after = 1'b1;
        logic prev_stall = 1'b0;
        logic prev_addr  = 1'b0;

        id_s[d]     = id;
        ts_s[d]     = ts;
        stall_id[d] = sid;
        stall_ts[d] = sts;
        e      = predict(id, ts, sid, sts, lat, to, last_id[d], last_ts[d]);
        exp_rd = (sid >= to) ? to : (sid + 1 + ((sts >= to) ? to : sts + 1));

        @(negedge clock);
        if (use_start) start_v[d] = 1'b1;
        else rst_n_v[d] = 1'b1;
        @(posedge clock); #1;
        start_v[d] = 1'b0;
        for (int cyc = 1; cyc <= e.done_cyc + 3; cyc++) begin
            if (prev_stall && rd_cyc < exp_rd && (rd_o[d] !== 1'b1 || addr_o[d] !== prev_addr))
                hold_bad++;
            prev_stall = rd_o[d] && wr_o[d];
            prev_addr  = addr_o[d];
            if (rd_o[d]) rd_cyc++;
            if (done_o[d]) begin
                dones++;
                if (done_at < 0) begin
                    done_at   = cyc;
                    busy_done = busy_o[d];
                end
            end
            if (done_at >= 0 && cyc == done_at + 1) busy_after = busy_o[d];
            start_v[d] = poke && (cyc == 2 || cyc == e.done_cyc);
            @(posedge clock); #1;
        end
        start_v[d] = 1'b0;

        check({tag, "_done_cycle"}, 32'(done_at), 32'(e.done_cyc));
        check({tag, "_done_pulses"}, 32'(dones), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy_done), 32'd1);
        check({tag, "_busy_after_done"}, 32'(busy_after), 32'd0);
        check({tag, "_read_cycles"}, 32'(rd_cyc), 32'(exp_rd));
        check({tag, "_hold_violations"}, 32'(hold_bad), 32'd0);
        check({tag, "_id_ok"}, 32'(idok_o[d]), 32'(e.id_ok));
        check({tag, "_ts_ok"}, 32'(tsok_o[d]), 32'(e.ts_ok));
        check({tag, "_timeout_err"}, 32'(toerr_o[d]), 32'(e.to_err));
        check({tag, "_id_value"}, idv_o[d], e.id_v);
        check({tag, "_ts_value"}, tsv_o[d], e.ts_v);
        check({tag, "_stays_idle"}, {30'd0, rd_o[d], busy_o[d]}, 32'd0);
        last_id[d] = e.id_v;
        last_ts[d] = e.ts_v;
    endtask

    initial begin
        logic [31:0] rid, rts;

        rst_n_v = 2'b11;
        #1 rst_n_v = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", {30'd0, busy_o}, 32'd0);
        check("reset_done", {30'd0, done_o}, 32'd0);
        check("reset_read", {30'd0, rd_o}, 32'd0);
        check("reset_flags", {26'd0, idok_o, tsok_o, toerr_o}, 32'd0);
        check("reset_id_value", idv_o[0], 32'd0);
        check("reset_ts_value", tsv_o[0], 32'd0);

        // dut_a: automatic check, mismatch, stall on the timestamp read.
        run(0, "t1_auto", EXP_ID, EXP_TS, 0, 0, 1'b0, 1'b0);
        run(0, "t2_mismatch", EXP_ID, EXP_TS + 32'd1, 0, 0, 1'b1, 1'b0);
        run(0, "t3_stall", EXP_ID, EXP_TS, 0, 10, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rid = ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom();
            rts = ($urandom_range(0, 1) != 0) ? EXP_TS : $urandom();
            run(0, $sformatf("rand_a%0d", i), rid, rts,
                int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 1'b1, 1'b0);
        end

        // start while busy and in the done cycle must both be ignored.
        run(0, "t6_start_poke", EXP_ID, EXP_TS, 1, 2, 1'b1, 1'b1);

        // Reset in the middle of a stalled timestamp read.
        id_s[0]     = EXP_ID;
        ts_s[0]     = EXP_TS;
        stall_id[0] = 0;
        stall_ts[0] = 8;
        @(negedge clock);
        start_v[0] = 1'b1;
        @(posedge clock); #1;
        start_v[0] = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        check("t6_in_rd_ts", {30'd0, rd_o[0], addr_o[0]}, 32'd3);
        #2 rst_n_v[0] = 1'b0;
        #1;
        check("t6_reset_read", 32'(rd_o[0]), 32'd0);
        check("t6_reset_busy", 32'(busy_o[0]), 32'd0);
        check("t6_reset_ts_value", tsv_o[0], 32'd0);
        last_id[0] = 32'd0;
        last_ts[0] = 32'd0;
        repeat (2) @(negedge clock);
        run(0, "t6_relaunch", EXP_ID, EXP_TS, 0, 0, 1'b0, 1'b0);

        // dut_b: stuck waitrequest from auto start, then latency-2 checks.
        run(1, "t4_timeout", EXP_ID, EXP_TS, TO_B, 0, 1'b0, 1'b0);
        run(1, "t5_lat2", EXP_ID, EXP_TS, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rid = ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom();
            rts = ($urandom_range(0, 1) != 0) ? EXP_TS : $urandom();
            run(1, $sformatf("rand_b%0d", i), rid, rts, 0, 0, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
